// File: rtl/dly_pkg.sv
// Shared constants and helpers for the variable delay line and its users.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dly_pkg;

   // Defaults used by the delay line and by top-level path-matching arithmetic
   localparam int DFLT_MAX_DELAY   = 64;
   localparam int DFLT_RESET_DELAY = 8;

   // Width of a delay field able to hold 0..max_delay
   function automatic int dly_width(input int max_delay);
      return $clog2(max_delay + 1);
   endfunction

   // Map a requested delay onto the supported range 1..max_delay
   function automatic int unsigned dly_clamp(input int unsigned req, input int unsigned max_delay);
      if (req == 0) begin
         return 1;
      end else if (req > max_delay) begin
         return max_delay;
      end else begin
         return req;
      end
   endfunction

endpackage

// File: rtl/dly_sdp_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Latency: read data valid one cycle after the read address; read-before-write on collision.
// Backpressure: none, both ports accept an access every cycle.
module dly_sdp_ram #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 64,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_dat_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_dat_q;

   // Write port: storage only, no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      if (rd_en_i) begin
         rd_dat_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel sample delay line, delay programmable at run time from 1 to MAX_DELAY cycles.
// Latency: a sample in cycle t emerges registered in cycle t+D; reconfiguration flushes for D cycles.
// Backpressure: none; one slot per cycle, invalid cycles occupy slots and emerge invalid.
module var_delay_line
   import dly_pkg::*;
#(
   parameter int D_WIDTH     = 32,
   parameter int N_CH        = 2,
   parameter int MAX_DELAY   = DFLT_MAX_DELAY,
   parameter int RESET_DELAY = DFLT_RESET_DELAY,
   localparam int DW         = dly_width(MAX_DELAY)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_load,
   input  logic [DW-1:0]           delay_cfg,
   input  logic [N_CH*D_WIDTH-1:0] data_in,
   input  logic                    data_in_valid,
   output logic [N_CH*D_WIDTH-1:0] data_out,
   output logic                    data_out_valid,
   output logic [DW-1:0]           delay_cur,
   output logic                    flushing
);

   localparam int AW = $clog2(MAX_DELAY);
   localparam int W  = N_CH * D_WIDTH;

   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [MAX_DELAY-1:0] vld_q, vld_d;
   logic [DW-1:0]        delay_q, delay_d;
   logic [DW-1:0]        flush_cnt_q, flush_cnt_d;
   logic                 flushing_q, flushing_d;
   logic [W-1:0]         dout_q, dout_d;
   logic                 dout_vld_q, dout_vld_d;
   logic [W-1:0]         din_q;
   logic [W-1:0]         ram_rd_dat;
   logic [W-1:0]         sel_dat;
   logic [DW-1:0]        cfg_delay;
   logic [DW-1:0]        ram_back, vld_back;
   logic [AW-1:0]        ram_rd_addr, vld_rd_idx;

   // Circular index 'back' slots behind ptr; back is always below MAX_DELAY
   function automatic logic [AW-1:0] ptr_back(input logic [AW-1:0] ptr, input logic [DW-1:0] back);
      int unsigned idx;
      idx = 32'(ptr) + 32'(MAX_DELAY) - 32'(back);
      if (idx >= 32'(MAX_DELAY)) begin
         idx = idx - 32'(MAX_DELAY);
      end
      return AW'(idx);
   endfunction

   assign cfg_delay = DW'(dly_clamp(32'(delay_cfg), 32'(MAX_DELAY)));

   // Read positions: the output register is loaded one cycle before the sample is due, and
   // the RAM read is issued one cycle before that. D=1 and D=2 are too short for the RAM
   // and are served from data_in and din_q instead.
   always_comb begin
      vld_back = delay_q - DW'(1);
      ram_back = (delay_q >= DW'(2)) ? (delay_q - DW'(2)) : '0;
   end

   assign ram_rd_addr = ptr_back(wr_ptr_q, ram_back);
   assign vld_rd_idx  = ptr_back(wr_ptr_q, vld_back);

   dly_sdp_ram #(
      .WIDTH (W),
      .DEPTH (MAX_DELAY)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (1'b1),
      .wr_addr_i (wr_ptr_q),
      .wr_dat_i  (data_in),
      .rd_en_i   (1'b1),
      .rd_addr_i (ram_rd_addr),
      .rd_dat_o  (ram_rd_dat)
   );

   // Slot bookkeeping: pointer walks every cycle; reconfiguration drops all in-flight flags
   // but keeps the sample arriving with the strobe as the first of the new regime
   always_comb begin
      wr_ptr_d = (wr_ptr_q == AW'(MAX_DELAY - 1)) ? '0 : (wr_ptr_q + AW'(1));
      vld_d    = cfg_load ? '0 : vld_q;
      vld_d[wr_ptr_q] = data_in_valid;
      delay_d  = cfg_load ? cfg_delay : delay_q;
   end

   // Flush window covers the D_new cycles following the strobe; a new strobe restarts it
   always_comb begin
      flushing_d  = flushing_q;
      flush_cnt_d = flush_cnt_q;
      if (cfg_load) begin
         flushing_d  = 1'b1;
         flush_cnt_d = cfg_delay - DW'(1);
      end else if (flush_cnt_q != '0) begin
         flush_cnt_d = flush_cnt_q - DW'(1);
      end else begin
         flushing_d = 1'b0;
      end
   end

   // Output selection; a strobe suppresses old-regime data unless the new delay is one cycle
   always_comb begin
      dout_vld_d = 1'b0;
      sel_dat    = ram_rd_dat;
      if (cfg_load) begin
         if (cfg_delay == DW'(1)) begin
            dout_vld_d = data_in_valid;
            sel_dat    = data_in;
         end
      end else if (delay_q == DW'(1)) begin
         dout_vld_d = data_in_valid;
         sel_dat    = data_in;
      end else begin
         dout_vld_d = vld_q[vld_rd_idx];
         sel_dat    = (delay_q == DW'(2)) ? din_q : ram_rd_dat;
      end
      dout_d = dout_vld_d ? sel_dat : dout_q;
   end

   // Control and output state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         vld_q       <= '0;
         delay_q     <= DW'(RESET_DELAY);
         flush_cnt_q <= '0;
         flushing_q  <= 1'b0;
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         vld_q       <= vld_d;
         delay_q     <= delay_d;
         flush_cnt_q <= flush_cnt_d;
         flushing_q  <= flushing_d;
         dout_q      <= dout_d;
         dout_vld_q  <= dout_vld_d;
      end
   end

   // One-cycle copy of the input for the D=2 path
   always_ff @(posedge clk) begin
      din_q <= data_in;
   end

   assign data_out       = dout_q;
   assign data_out_valid = dout_vld_q;
   assign delay_cur      = delay_q;
   assign flushing       = flushing_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: ramp, sparse valid, clamping, reconfiguration, reset.
// Latency: each test drives one cycle at a time and checks outputs on the falling edge.
// Backpressure: n/a.
module tb_var_delay_line;

   localparam int D_WIDTH     = 32;
   localparam int N_CH        = 2;
   localparam int MAX_DELAY   = 64;
   localparam int RESET_DELAY = 8;
   localparam int DW          = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_load;
   logic [DW-1:0] delay_cfg;
   logic [63:0]   data_in;
   logic          data_in_valid;
   logic [63:0]   data_out;
   logic          data_out_valid;
   logic [DW-1:0] delay_cur;
   logic          flushing;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_hold;

   always #5 clk = ~clk;

   var_delay_line #(
      .D_WIDTH     (D_WIDTH),
      .N_CH        (N_CH),
      .MAX_DELAY   (MAX_DELAY),
      .RESET_DELAY (RESET_DELAY)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_load       (cfg_load),
      .delay_cfg      (delay_cfg),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .delay_cur      (delay_cur),
      .flushing       (flushing)
   );

   // ch0 carries the value, ch1 its complement
   function automatic logic [63:0] pack(input logic [31:0] v);
      return {~v, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_load = 1'b0; delay_cfg = '0; data_in = '0; data_in_valid = 1'b0;
      tick();
      tick();
      @(negedge clk);
      exp_hold = '0;
      checks += 4;
      if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_out); end
      if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%0b exp=0", data_out_valid); end
      if (flushing !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flushing); end
      if (delay_cur !== 7'd8) begin errors++; $display("FAIL reset_delay got=%0d exp=8", delay_cur); end
      tick();
   endtask

   task automatic test_default_ramp();
      logic exp_vld;
      int   s;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cfg_load = 1'b0;
         data_in_valid = (i < 30);
         data_in = (i < 30) ? pack(32'(i + 1)) : pack(32'hDEAD_0000 + 32'(i));
         @(negedge clk);
         s = i - 8;
         exp_vld = (s >= 0 && s < 30);
         if (exp_vld) exp_hold = pack(32'(s + 1));
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL ramp_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL ramp_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== 1'b0) begin errors++; $display("FAIL ramp_flush cyc=%0d got=%0b exp=0", i, flushing); end
         if (delay_cur !== 7'd8) begin errors++; $display("FAIL ramp_delay cyc=%0d got=%0d exp=8", i, delay_cur); end
         tick();
      end
   endtask

   task automatic test_sparse();
      logic          exp_vld, exp_fl;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 15; i++) begin
         cfg_load = (i == 0); delay_cfg = 7'd5;
         data_in_valid = (i == 0 || i == 3 || i == 4);
         data_in = pack(32'hA0 + 32'(i));
         @(negedge clk);
         exp_vld = (i == 5 || i == 8 || i == 9);
         if (exp_vld) exp_hold = pack(32'hA0 + 32'(i - 5));
         exp_fl = (i >= 1 && i <= 5);
         exp_d  = (i == 0) ? 7'd8 : 7'd5;
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL sparse_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL sparse_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL sparse_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL sparse_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
   endtask

   task automatic test_cfg_zero();
      logic          exp_vld, exp_fl;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 9; i++) begin
         cfg_load = (i == 0); delay_cfg = 7'd0;
         data_in_valid = (i <= 5);
         data_in = pack(32'hB0 + 32'(i));
         @(negedge clk);
         exp_vld = (i >= 1 && i <= 6);
         if (exp_vld) exp_hold = pack(32'hB0 + 32'(i - 1));
         exp_fl = (i == 1);
         exp_d  = (i == 0) ? 7'd5 : 7'd1;
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL cfg0_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL cfg0_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL cfg0_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL cfg0_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
   endtask

   // 200 continuous samples at the maximum delay: more than three pointer wraps
   task automatic test_cfg_max();
      logic          exp_vld, exp_fl;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 271; i++) begin
         cfg_load = (i == 0); delay_cfg = 7'd64;
         data_in_valid = (i < 200);
         data_in = pack(32'hC000_0000 + 32'(i));
         @(negedge clk);
         exp_vld = (i >= 64 && i < 264);
         if (exp_vld) exp_hold = pack(32'hC000_0000 + 32'(i - 64));
         exp_fl = (i >= 1 && i <= 64);
         exp_d  = (i == 0) ? 7'd1 : 7'd64;
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL cfg64_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL cfg64_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL cfg64_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL cfg64_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
   endtask

   task automatic test_cfg_over();
      logic exp_vld, exp_fl;
      for (int i = 0; i < 67; i++) begin
         cfg_load = (i == 0); delay_cfg = 7'd100;
         data_in_valid = (i == 0);
         data_in = (i == 0) ? pack(32'h0000_D1D1) : pack(32'h5A5A_0000 + 32'(i));
         @(negedge clk);
         exp_vld = (i == 64);
         if (exp_vld) exp_hold = pack(32'h0000_D1D1);
         exp_fl = (i >= 1 && i <= 64);
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL cfg100_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL cfg100_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL cfg100_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== 7'd64) begin errors++; $display("FAIL cfg100_delay cyc=%0d got=%0d exp=64", i, delay_cur); end
         tick();
      end
   endtask

   // D=8 from cycle 0, then 8 -> 3 at cycle 20 with continuous valid
   task automatic test_reconfig_mid();
      logic          exp_vld, exp_fl;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 33; i++) begin
         cfg_load = (i == 0 || i == 20);
         delay_cfg = (i == 20) ? 7'd3 : 7'd8;
         data_in_valid = (i <= 28);
         data_in = pack(32'hE00 + 32'(i));
         @(negedge clk);
         exp_vld = 1'b0;
         if (i >= 8 && i <= 20) begin
            exp_vld = 1'b1; exp_hold = pack(32'hE00 + 32'(i - 8));
         end else if (i >= 23 && i <= 31) begin
            exp_vld = 1'b1; exp_hold = pack(32'hE00 + 32'(i - 3));
         end
         exp_fl = (i >= 1 && i <= 8) || (i >= 21 && i <= 23);
         exp_d  = (i == 0) ? 7'd64 : ((i <= 20) ? 7'd8 : 7'd3);
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL mid_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL mid_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL mid_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL mid_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
   endtask

   // Strobes at cycle 10 (D=20) and cycle 12 (D=4) while D=3 is in force
   task automatic test_back_to_back();
      logic          exp_vld, exp_fl;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 37; i++) begin
         cfg_load = (i == 10 || i == 12);
         delay_cfg = (i == 10) ? 7'd20 : 7'd4;
         data_in_valid = (i <= 30);
         data_in = pack(32'hF00 + 32'(i));
         @(negedge clk);
         exp_vld = 1'b0;
         if (i >= 3 && i <= 10) begin
            exp_vld = 1'b1; exp_hold = pack(32'hF00 + 32'(i - 3));
         end else if (i >= 16 && i <= 34) begin
            exp_vld = 1'b1; exp_hold = pack(32'hF00 + 32'(i - 4));
         end
         exp_fl = (i >= 11 && i <= 16);
         exp_d  = (i <= 10) ? 7'd3 : ((i <= 12) ? 7'd20 : 7'd4);
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL b2b_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== exp_fl) begin errors++; $display("FAIL b2b_flush cyc=%0d got=%0b exp=%0b", i, flushing, exp_fl); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL b2b_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
   endtask

   // One-cycle reset at cycle 10 (with a competing cfg_load) while D=4 data is in flight
   task automatic test_reset_midstream();
      logic          exp_vld;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 26; i++) begin
         rst = (i == 10);
         cfg_load = (i == 10); delay_cfg = 7'd2;
         data_in_valid = 1'b1;
         data_in = pack(32'h1100 + 32'(i));
         @(negedge clk);
         if (i == 11) exp_hold = '0;
         exp_vld = 1'b0;
         if (i >= 4 && i <= 10) begin
            exp_vld = 1'b1; exp_hold = pack(32'h1100 + 32'(i - 4));
         end else if (i >= 19) begin
            exp_vld = 1'b1; exp_hold = pack(32'h1100 + 32'(i - 8));
         end
         exp_d = (i <= 10) ? 7'd4 : 7'd8;
         checks += 4;
         if (data_out_valid !== exp_vld) begin errors++; $display("FAIL rstmid_vld cyc=%0d got=%0b exp=%0b", i, data_out_valid, exp_vld); end
         if (data_out !== exp_hold) begin errors++; $display("FAIL rstmid_data cyc=%0d got=%h exp=%h", i, data_out, exp_hold); end
         if (flushing !== 1'b0) begin errors++; $display("FAIL rstmid_flush cyc=%0d got=%0b exp=0", i, flushing); end
         if (delay_cur !== exp_d) begin errors++; $display("FAIL rstmid_delay cyc=%0d got=%0d exp=%0d", i, delay_cur, exp_d); end
         tick();
      end
      rst = 1'b0; cfg_load = 1'b0; data_in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_ramp();
      test_sparse();
      test_cfg_zero();
      test_cfg_max();
      test_cfg_over();
      test_reconfig_mid();
      test_back_to_back();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
